clk_enable_gen: RTL and testbench
=================================

# clk_enable_gen

- Parametrised, fully digital N-channel clock-enable generator; the single-clock successor to the two-output fixed PLL wrapper.
- From one reference clock it derives, per channel, a one-cycle enable pulse and a square-wave level with a programmable divide ratio and phase offset.
- Provides a lock indication after a settle period, and runtime reconfiguration through a valid/ready handshake.
- Sits between the board PLL output and the SDRAM/video/control logic that needs slower, phase-related rates without extra PLL outputs.

## Interface
- NUM_CH, 2: number of output channels, 1..16.
- DIV_W, 8: width of divide and phase fields.
- DEF_DIV, 2: divide ratio loaded into every channel at reset.
- LOCK_CYCLES, 16: settle cycles before `locked` asserts, ≥1.
- refclk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  reconfiguration request.
- cfg_ready  out  1  request accepted when cfg_valid & cfg_ready at the edge.
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel.
- cfg_div  in  DIV_W  new divide ratio; 0 is treated as 1.
- cfg_phase  in  DIV_W  new phase offset.
- outen  out  NUM_CH  per-channel enable pulse, one cycle per period.
- outclk  out  NUM_CH  per-channel divided square wave.
- locked  out  1  all channels aligned and settled.

## Operation
- Per channel state:
  - div register, reset to DEF_DIV.
  - phase register, reset to 0.
  - period counter cnt, 0..div-1, wraps to 0 after div-1.
- Effective phase is min(phase, div-1). Effective div is max(div, 1).
- outen[n] = 1 when cnt == effective phase.
- outclk[n] = 1 when cnt < (div+1)>>1. Consequences:
  - div=1: outclk constant high.
  - div=3: high for 2 of 3 cycles.
- FSM states ALIGN, SETTLE, LOCKED:
  - rst: state ← ALIGN; all cnt ← 0; settle counter ← 0; all outputs 0; registers ← defaults.
  - ALIGN: counters held at 0, outputs 0, cfg_ready 0. Next state is always SETTLE.
  - SETTLE: counters run; settle counter increments each cycle. At settle counter == LOCK_CYCLES-1, go to LOCKED.
  - LOCKED: counters run; locked = 1.
- Reconfiguration:
  - cfg_ready = 1 in SETTLE and LOCKED.
  - On accept with cfg_ch < NUM_CH: write div/phase of that channel, go to ALIGN. All channels realign together, and the settle counter restarts.
  - On accept with cfg_ch ≥ NUM_CH: the request is consumed and ignored. No state change; locked unaffected.
- Simultaneous rst and accepted request: rst wins; the request is dropped.

## Timing
- All outputs are registered. Reset value of outen, outclk, locked and cfg_ready is 0.
- Edge E1 (first edge with rst low): ALIGN→SETTLE. cfg_ready = 1 from E1.
- Counters advance from edge E2.
- outen/outclk reflect counter value cnt(k) after edge k+1, i.e. one-cycle registered decode.
- The first outen for a phase-0 channel is visible after E2.
- locked rises after edge E(1+LOCK_CYCLES) and stays high until the next accept or rst.
- Accepted request at edge A:
  - State is ALIGN and locked is 0 after A.
  - outen/outclk are 0 after A+1.
  - The cycle sequence then repeats exactly as from E1.
- All channels share a common cnt=0 instant after every ALIGN, so enables with equal div are phase-exact relative to each other.

## Configuration
- Macro CLK_ENABLE_GEN_RECONFIG_EN.
- Defined: handshake port functional, as described above.
- Undefined:
  - cfg_ready tied 0 and cfg_* inputs ignored.
  - div/phase registers become constants (DEF_DIV, 0).
  - FSM only ever runs ALIGN→SETTLE→LOCKED once per reset.

## Test plan
- Reset release, defaults (NUM_CH=2, DEF_DIV=2, LOCK_CYCLES=16) -> both outen pulse every 2 cycles, coincident; first pulse after E2; locked rises after E17.
- Locked, request ch1 div=5 phase=3 -> cfg_ready low and locked 0 the next cycle. Then outen[1] period 5, asserting 3 cycles after each outen[0] coincident with cnt=0. outclk[1] high 3, low 2. locked returns 17 cycles after the accept.
- Request ch0 div=4 phase=7 -> behaves identically to phase=3.
- Request ch0 div=0 -> outen[0] and outclk[0] constant 1 after realign.
- Request cfg_ch=3 while locked -> cfg_ready stays 1, no realign, locked stays 1, outputs undisturbed.
- Assert rst for one cycle during ALIGN after a reconfig -> all div back to 2, outputs 0, sequence restarts as in scenario 1.

Source files
------------

// File: rtl/clk_enable_gen_if.sv
// clk_enable_gen_if: reconfiguration handshake (cfg_valid/cfg_ready, cfg_ch, cfg_div, cfg_phase) between a controller (master) and clk_enable_gen (slave)
interface clk_enable_gen_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W = 8
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic cfg_valid;
  logic cfg_ready;
  logic [CH_W-1:0] cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [DIV_W-1:0] cfg_phase;
  modport master(output cfg_valid, cfg_ch, cfg_div, cfg_phase, input cfg_ready);
  modport slave(input cfg_valid, cfg_ch, cfg_div, cfg_phase, output cfg_ready);
endinterface

// File: rtl/clk_enable_gen.sv
// clk_enable_gen: N-channel clock-enable generator; ports refclk, rst (sync high), cfg (clk_enable_gen_if.slave), outen/outclk [NUM_CH], locked; runtime reconfig enabled by CLK_ENABLE_GEN_RECONFIG_EN
module clk_enable_gen #(
  parameter int NUM_CH = 2,
  parameter int DIV_W = 8,
  parameter int DEF_DIV = 2,
  parameter int LOCK_CYCLES = 16
) (
  input  logic refclk,
  input  logic rst,
  clk_enable_gen_if.slave cfg,
  output logic [NUM_CH-1:0] outen,
  output logic [NUM_CH-1:0] outclk,
  output logic locked
);
  localparam int SW = $clog2(LOCK_CYCLES + 1);
  typedef enum logic [1:0] {ALIGN, SETTLE, LOCKED} state_t;
  state_t state, state_nx;
  logic [SW-1:0] settle;
  logic hit;
`ifdef CLK_ENABLE_GEN_RECONFIG_EN
  assign cfg.cfg_ready = state != ALIGN;
  assign hit = cfg.cfg_valid && state != ALIGN && 32'(cfg.cfg_ch) < NUM_CH;
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg.cfg_valid, cfg.cfg_ch, cfg.cfg_div, cfg.cfg_phase};
  assign cfg.cfg_ready = 1'b0;
  assign hit = 1'b0;
`endif
  always_comb begin
    state_nx = hit ? ALIGN :
               state == ALIGN ? SETTLE :
               (state == SETTLE && settle == SW'(LOCK_CYCLES - 1)) ? LOCKED : state;
  end
  always_ff @(posedge refclk) begin
    if (rst) begin
      state <= ALIGN;
      settle <= '0;
      locked <= 1'b0;
    end else begin
      state <= state_nx;
      settle <= state == SETTLE ? settle + SW'(1) : '0;
      locked <= state_nx == LOCKED;
    end
  end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] div, phase, cnt, div_e, div_m1, ph_e;
    logic [DIV_W:0] half;
    logic en_q, ck_q;
`ifdef CLK_ENABLE_GEN_RECONFIG_EN
    always_ff @(posedge refclk) begin
      if (rst) begin
        div <= DIV_W'(DEF_DIV);
        phase <= '0;
      end else if (hit && 32'(cfg.cfg_ch) == g) begin
        div <= cfg.cfg_div;
        phase <= cfg.cfg_phase;
      end
    end
`else
    assign div = DIV_W'(DEF_DIV);
    assign phase = '0;
`endif
    assign div_e = div == '0 ? DIV_W'(1) : div;
    assign div_m1 = div_e - DIV_W'(1);
    assign ph_e = phase > div_m1 ? div_m1 : phase;
    assign half = ({1'b0, div_e} + (DIV_W + 1)'(1)) >> 1;
    always_ff @(posedge refclk) begin
      if (rst || state == ALIGN) begin
        cnt <= '0;
        en_q <= 1'b0;
        ck_q <= 1'b0;
      end else begin
        cnt <= cnt >= div_m1 ? '0 : cnt + DIV_W'(1);
        en_q <= cnt == ph_e;
        ck_q <= {1'b0, cnt} < half;
      end
    end
    assign outen[g] = en_q;
    assign outclk[g] = ck_q;
  end
endmodule

// File: tb/tb_clk_enable_gen.sv
// tb_clk_enable_gen: table-driven self-checking bench for clk_enable_gen (NUM_CH=3 so cfg_ch=3 is out of range)
module tb_clk_enable_gen;
`ifdef CLK_ENABLE_GEN_RECONFIG_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  logic refclk = 1'b0;
  logic rst;
  logic [2:0] outen, outclk;
  logic locked;
  int tests = 0;
  int fails = 0;
  clk_enable_gen_if #(.NUM_CH(3), .DIV_W(8)) cfg();
  clk_enable_gen #(.NUM_CH(3), .DIV_W(8), .DEF_DIV(2), .LOCK_CYCLES(16)) dut (
    .refclk(refclk),
    .rst(rst),
    .cfg(cfg),
    .outen(outen),
    .outclk(outclk),
    .locked(locked)
  );
  always #5 refclk = ~refclk;
  typedef struct {
    logic rs;
    logic v;
    int ch;
    int dv;
    int ph;
    logic [7:0] exp;
  } vec_t;
  vec_t tv[$];
  int md[3];
  int mp[3];
  int r;
  function automatic logic [1:0] chexp(int rr, int dv, int ph);
    int d, p, c;
    d = dv == 0 ? 1 : dv;
    p = ph > d - 1 ? d - 1 : ph;
    if (rr < 2) return 2'b00;
    c = (rr - 2) % d;
    return {c == p, c < (d + 1) / 2};
  endfunction
  task automatic add(input logic rs, input logic v, input int ch, input int dv, input int ph);
    vec_t t;
    logic hit;
    logic [2:0] en, ck;
    hit = RC && !rs && v && ch < 3 && r >= 1;
    r = rs ? 0 : r + 1;
    for (int c = 0; c < 3; c++) {en[c], ck[c]} = chexp(r, md[c], mp[c]);
    t.rs = rs;
    t.v = v;
    t.ch = ch;
    t.dv = dv;
    t.ph = ph;
    t.exp = {en, ck, r >= 17 && !hit, RC && r >= 1 && !hit};
    tv.push_back(t);
    if (rs) for (int c = 0; c < 3; c++) begin
      md[c] = 2;
      mp[c] = 0;
    end
    if (hit) begin
      md[ch] = dv;
      mp[ch] = ph;
      r = 0;
    end
  endtask
  task automatic idle(input int n);
    repeat (n) add(1'b0, 1'b0, 0, 0, 0);
  endtask
  task automatic tick;
    @(posedge refclk);
    #1;
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n, m, hc;
    logic [7:0] act;
    rst = 1'b1;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_ch = '0;
    cfg.cfg_div = '0;
    cfg.cfg_phase = '0;
    r = 0;
    for (int c = 0; c < 3; c++) begin
      md[c] = 2;
      mp[c] = 0;
    end
    add(1'b1, 1'b0, 0, 0, 0);
    add(1'b1, 1'b0, 0, 0, 0);
    idle(20);
    add(1'b0, 1'b1, 1, 5, 3);
    idle(24);
    add(1'b0, 1'b1, 0, 4, 7);
    idle(20);
    add(1'b0, 1'b1, 0, 0, 0);
    idle(20);
    add(1'b0, 1'b1, 3, 9, 1);
    idle(6);
    add(1'b0, 1'b1, 1, 3, 0);
    add(1'b1, 1'b0, 0, 0, 0);
    idle(20);
    add(1'b1, 1'b1, 1, 7, 2);
    idle(20);
    foreach (tv[i]) begin
      rst = tv[i].rs;
      cfg.cfg_valid = tv[i].v;
      cfg.cfg_ch = 2'(tv[i].ch);
      cfg.cfg_div = 8'(tv[i].dv);
      cfg.cfg_phase = 8'(tv[i].ph);
      tick();
      act = {outen, outclk, locked, cfg.cfg_ready};
      tests++;
      if (act !== tv[i].exp) begin
        fails++;
        $display("FAIL vec%0d: got en/ck/lk/rdy=%b want %b", i, act, tv[i].exp);
      end
    end
    rst = 1'b0;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch = 2'd1;
    cfg.cfg_div = 8'd5;
    cfg.cfg_phase = 8'd3;
    tick();
    cfg.cfg_valid = 1'b0;
    chk("ready after accept", int'(cfg.cfg_ready), RC ? 0 : 0);
    chk("locked after accept", int'(locked), RC ? 0 : 1);
    n = 0;
    while (!locked && n < 40) begin
      tick();
      n++;
    end
    chk("relock edges", n, RC ? 17 : 0);
    m = 0;
    while (!outen[1] && m < 10) begin
      tick();
      m++;
    end
    chk("ch1 pulse seen", int'(outen[1]), 1);
    m = 0;
    hc = 0;
    do begin
      tick();
      m++;
      hc += int'(outclk[1]);
    end while (!outen[1] && m < 12);
    chk("ch1 period", m, RC ? 5 : 2);
    chk("ch1 high cycles", hc, RC ? 3 : 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
